// File: rtl/ecp5_pll_phase_ctrl.sv
// rtl/ecp5_pll_phase_ctrl.sv - ECP5 EHXPLLL dynamic phase-shift sequencer
//
// Purpose:
//   Takes one phase-move request (output select, direction, step count) over
//   a valid/ready handshake. It drives the PLL PHASESEL/PHASEDIR pins and
//   emits spaced active-low PHASESTEP pulses, then one PHASELOADREG pulse.
//   It then waits for the PLL to re-lock and reports done, with err set on a
//   lock timeout. The block runs on the PLL reference clock.
//
// Ports:
//   i_clk                 reference clock
//   i_rst_n               asynchronous active-low reset
//   i_req_valid           request valid
//   o_req_ready           high only while idle
//   i_req_sel[1:0]        PLL output to shift (0=CLKOP .. 3=CLKOS3)
//   i_req_dir             shift direction, forwarded to PHASEDIR
//   i_req_steps[STEP_W-1:0] number of PHASESTEP pulses
//   o_busy                high whenever a request is in progress
//   o_done                one-cycle completion pulse
//   o_err                 lock timeout flag, valid with o_done, held until next accept
//   o_lock_lost           sticky: synced lock fell while idle
//   i_pll_locked          PLL LOCK, asynchronous to i_clk
//   o_pll_phasesel[1:0]   to PHASESEL
//   o_pll_phasedir        to PHASEDIR
//   o_pll_phasestep       to PHASESTEP, idle high
//   o_pll_phaseloadreg    to PHASELOADREG, idle high

module ecp5_pll_phase_ctrl #(
  parameter int STEP_W      = 4,
  parameter int SETUP_CYC   = 4,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 4,
  parameter int LOCK_CYC    = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_sel,
  input  logic              i_req_dir,
  input  logic [STEP_W-1:0] i_req_steps,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_lock_lost,
  input  logic              i_pll_locked,
  output logic [1:0]        o_pll_phasesel,
  output logic              o_pll_phasedir,
  output logic              o_pll_phasestep,
  output logic              o_pll_phaseloadreg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_STEP_LO   = 3'd2;
  localparam logic [2:0] S_STEP_HI   = 3'd3;
  localparam logic [2:0] S_LOAD_LO   = 3'd4;
  localparam logic [2:0] S_LOAD_HI   = 3'd5;
  localparam logic [2:0] S_LOCK_WAIT = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam int RUN_W = $clog2(LOCK_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  // Phase counters are loaded with N-1 and leave their state on reaching 0.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  localparam logic [RUN_W-1:0]  RUN_DONE = RUN_W'(LOCK_CYC);
  // The done/err outputs trail the DONE state by one register stage, so the
  // timeout leaves LOCK_WAIT one cycle early. That way done is seen exactly
  // TIMEOUT_CYC cycles after LOCK_WAIT was entered.
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);

  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

  logic [2:0]        r_state;
  logic [7:0]        r_cnt;
  logic [STEP_W-1:0] r_rem;
  logic [RUN_W-1:0]  r_run;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_err_pend;
  logic              r_lk_meta;
  logic              r_lk;
  logic              r_lk_d;

  logic [2:0]        w_state_nxt;
  logic [7:0]        w_cnt_nxt;
  logic [STEP_W-1:0] w_rem_nxt;
  logic [STEP_W-1:0] w_rem_dec;
  logic [RUN_W-1:0]  w_run_nxt;
  logic [TMO_W-1:0]  w_tmo_nxt;
  logic              w_err_nxt;
  logic              w_accept;
  logic              w_lk_fall;

  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  assign w_rem_dec = r_rem - STEP_ONE;
  assign w_lk_fall = r_lk_d && !r_lk;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_run_nxt   = r_run;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err_pend;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = SETUP_LD;
          w_rem_nxt   = i_req_steps;
        end
      end
      S_SETUP: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = (r_rem != '0) ? S_STEP_LO : S_LOAD_LO;
          w_cnt_nxt   = PULSE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_STEP_LO: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_STEP_HI;
          w_cnt_nxt   = GAP_LD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_STEP_HI: begin
        if (r_cnt == 8'd0) begin
          // Count down only here, so the maximum step count never wraps.
          w_rem_nxt   = w_rem_dec;
          w_state_nxt = (w_rem_dec != '0) ? S_STEP_LO : S_LOAD_LO;
          w_cnt_nxt   = PULSE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_LOAD_LO: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_LOAD_HI;
          w_cnt_nxt   = GAP_LD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_LOAD_HI: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_LOCK_WAIT;
          w_run_nxt   = '0;
          w_tmo_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_LOCK_WAIT: begin
        // Success is tested first, so it wins a tie with the timeout.
        if (r_run == RUN_DONE) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b0;
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_run_nxt = r_lk ? (r_run + RUN_ONE) : '0;
          w_tmo_nxt = r_tmo + TMO_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state            <= S_IDLE;
      r_cnt              <= 8'd0;
      r_rem              <= '0;
      r_run              <= '0;
      r_tmo              <= '0;
      r_err_pend         <= 1'b0;
      r_lk_meta          <= 1'b0;
      r_lk               <= 1'b0;
      r_lk_d             <= 1'b0;
      o_req_ready        <= 1'b1;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_err              <= 1'b0;
      o_lock_lost        <= 1'b0;
      o_pll_phasesel     <= 2'd0;
      o_pll_phasedir     <= 1'b1;
      o_pll_phasestep    <= 1'b1;
      o_pll_phaseloadreg <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rem      <= w_rem_nxt;
      r_run      <= w_run_nxt;
      r_tmo      <= w_tmo_nxt;
      r_err_pend <= w_err_nxt;

      r_lk_meta <= i_pll_locked;
      r_lk      <= r_lk_meta;
      r_lk_d    <= r_lk;

      // ready/busy follow the next state so that no cycle is left with
      // neither of them asserted.
      o_req_ready <= (w_state_nxt == S_IDLE);
      o_busy      <= (w_state_nxt != S_IDLE);
      o_done      <= (r_state == S_DONE);

      if (w_accept) begin
        o_err <= 1'b0;
      end else if (r_state == S_DONE) begin
        o_err <= r_err_pend;
      end

      // The clear on accept wins over a lock fall on the same cycle.
      if (w_accept) begin
        o_lock_lost <= 1'b0;
      end else if ((r_state == S_IDLE) && w_lk_fall) begin
        o_lock_lost <= 1'b1;
      end

      // sel/dir stay latched from accept until the next accept.
      if (w_accept) begin
        o_pll_phasesel <= i_req_sel;
        o_pll_phasedir <= i_req_dir;
      end

      o_pll_phasestep    <= (r_state != S_STEP_LO);
      o_pll_phaseloadreg <= (r_state != S_LOAD_LO);
    end
  end

endmodule

// File: tb/tb_ecp5_pll_phase_ctrl.sv
// tb/tb_ecp5_pll_phase_ctrl.sv - directed self-checking bench for ecp5_pll_phase_ctrl
module tb_ecp5_pll_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [3:0] req_steps;
  logic       busy;
  logic       done;
  logic       err;
  logic       lock_lost;
  logic       pll_locked;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir;
  logic       pll_phasestep;
  logic       pll_phaseloadreg;

  int total = 0;
  int bad   = 0;

  ecp5_pll_phase_ctrl dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .i_req_sel          (req_sel),
    .i_req_dir          (req_dir),
    .i_req_steps        (req_steps),
    .o_busy             (busy),
    .o_done             (done),
    .o_err              (err),
    .o_lock_lost        (lock_lost),
    .i_pll_locked       (pll_locked),
    .o_pll_phasesel     (pll_phasesel),
    .o_pll_phasedir     (pll_phasedir),
    .o_pll_phasestep    (pll_phasestep),
    .o_pll_phaseloadreg (pll_phaseloadreg)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-tick pin trace: count pulses, 4 low / 4 high, first low tick given.
  function automatic logic [255:0] pulse_vec(input int first, input int count);
    logic [255:0] v;
    v = '1;
    for (int i = 0; i < count; i++)
      for (int j = 0; j < 4; j++)
        v[first + 8 * i + j] = 1'b0;
    return v;
  endfunction

  task automatic send(input logic [1:0] sel, input logic dir, input logic [3:0] steps);
    req_sel   = sel;
    req_dir   = dir;
    req_steps = steps;
    req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
  endtask

  // Ticks until done (bounded); records pin traces, step falls, sel/dir changes.
  task automatic run_seq(input int limit, output int cyc, output logic [255:0] sv,
                         output logic [255:0] lv, output int nst, output logic selchg);
    logic       prev;
    logic [1:0] s0;
    logic       d0;
    sv = '1; lv = '1; nst = 0; cyc = 0; selchg = 1'b0;
    prev = pll_phasestep; s0 = pll_phasesel; d0 = pll_phasedir;
    for (int k = 1; k <= limit; k++) begin
      tick(1);
      if (k < 256) begin
        sv[k] = pll_phasestep;
        lv[k] = pll_phaseloadreg;
      end
      if (prev && !pll_phasestep) nst++;
      prev = pll_phasestep;
      if (pll_phasesel !== s0 || pll_phasedir !== d0) selchg = 1'b1;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  int           cyc;
  int           nst;
  int           donek;
  int           r;
  logic [255:0] sv;
  logic [255:0] lv;
  logic         selchg;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_sel = 2'd0; req_dir = 1'b0;
    req_steps = 4'd0; pll_locked = 1'b1;
    tick(3);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_sel", pll_phasesel, 0);
    chk("rst_dir", pll_phasedir, 1);
    chk("rst_step", pll_phasestep, 1);
    chk("rst_load", pll_phaseloadreg, 1);
    rst_n = 1'b1;
    tick(4);

    // T2: sel=1 dir=0 steps=3, lock held
    send(2'd1, 1'b0, 4'd3);
    chk("t2_ready_fall", req_ready, 0);
    chk("t2_busy", busy, 1);
    chk("t2_sel", pll_phasesel, 1);
    chk("t2_dir", pll_phasedir, 0);
    run_seq(200, cyc, sv, lv, nst, selchg);
    chk("t2_done_cyc", cyc, 54);
    chk("t2_nsteps", nst, 3);
    chkv("t2_step_trace", sv, pulse_vec(5, 3));
    chkv("t2_load_trace", lv, pulse_vec(29, 1));
    chk("t2_err", err, 0);
    chk("t2_selchg", selchg, 0);
    chk("t2_ready_back", req_ready, 1);
    chk("t2_busy_back", busy, 0);
    tick(1);
    chk("t2_done_pulse", done, 0);

    // maximum step count, no counter wrap
    send(2'd3, 1'b1, 4'd15);
    run_seq(400, cyc, sv, lv, nst, selchg);
    chk("t15_done_cyc", cyc, 150);
    chk("t15_nsteps", nst, 15);
    chkv("t15_step_trace", sv, pulse_vec(5, 15));
    chkv("t15_load_trace", lv, pulse_vec(125, 1));
    chk("t15_sel", pll_phasesel, 3);
    chk("t15_err", err, 0);
    tick(1);

    // T3: steps=0 still loads
    send(2'd2, 1'b1, 4'd0);
    run_seq(200, cyc, sv, lv, nst, selchg);
    chk("t3_done_cyc", cyc, 30);
    chk("t3_nsteps", nst, 0);
    chkv("t3_load_trace", lv, pulse_vec(5, 1));
    chk("t3_err", err, 0);
    tick(1);

    // T4: no lock -> timeout; LOCK_WAIT entered 12 ticks after accept
    send(2'd0, 1'b1, 4'd0);
    pll_locked = 1'b0;
    run_seq(5000, cyc, sv, lv, nst, selchg);
    chk("t4_done_cyc", cyc, 12 + 4096);
    chk("t4_err", err, 1);
    tick(1);
    chk("t4_done_pulse", done, 0);
    chk("t4_err_held", err, 1);
    chk("t4_lock_lost", lock_lost, 0);
    pll_locked = 1'b1;
    tick(4);

    // T5: lock toggles 8/8 in LOCK_WAIT, then holds
    send(2'd0, 1'b0, 4'd0);
    chk("t5_err_cleared", err, 0);
    donek = 0;
    for (int p = 0; p < 4; p++) begin
      pll_locked = 1'b1;
      for (int j = 0; j < 8; j++) begin tick(1); if (done) donek = 1; end
      pll_locked = 1'b0;
      for (int j = 0; j < 8; j++) begin tick(1); if (done) donek = 1; end
    end
    chk("t5_no_early_done", donek, 0);
    pll_locked = 1'b1;
    r = 0;
    for (int j = 1; j <= 100; j++) begin
      tick(1);
      if (done) begin r = j; break; end
    end
    chk("t5_done_after_rise", r, 20);
    chk("t5_err", err, 0);
    chk("t5_lock_lost", lock_lost, 0);
    tick(3);

    // T6: lock drop while idle
    pll_locked = 1'b0;
    tick(2);
    chk("t6_lost_early", lock_lost, 0);
    tick(1);
    chk("t6_lost_set", lock_lost, 1);
    pll_locked = 1'b1;
    send(2'd2, 1'b1, 4'd1);
    chk("t6_lost_cleared", lock_lost, 0);
    req_valid = 1'b1; req_sel = 2'd3; req_steps = 4'd5;
    tick(10);
    req_valid = 1'b0;
    chk("t6_sel_kept", pll_phasesel, 2);
    chk("t6_busy", busy, 1);
    run_seq(200, cyc, sv, lv, nst, selchg);
    chk("t6_done_cyc", cyc, 38 - 10);
    chk("t6_selchg", selchg, 0);
    tick(1);
    chk("t6_no_second_accept", busy, 0);
    chk("t6_lost_stays", lock_lost, 0);

    // T1: async reset mid STEP_LO
    send(2'd1, 1'b1, 4'd2);
    tick(6);
    chk("t1_pre_step_low", pll_phasestep, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_step", pll_phasestep, 1);
    chk("t1_busy", busy, 0);
    chk("t1_ready", req_ready, 1);
    chk("t1_sel", pll_phasesel, 0);
    chk("t1_dir", pll_phasedir, 1);
    chk("t1_load", pll_phaseloadreg, 1);
    chk("t1_done", done, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("t1_stays_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
